// File: rtl/structs.sv
// Shared FFT types and constants: default word widths, the frame state enum,
// and the helpers used for address generation.
package structs;

  localparam int unsigned SAMPLE_SIZE      = 16;
  localparam int unsigned TWIDDLE_SIZE     = 16;
  localparam int unsigned CALCULATION_SIZE = 20;
  localparam int unsigned BUFFER_SIZE      = 8;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StUnload
  } fft_state_e;

  // Ceiling log2; intended for elaboration-time sizing.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low 'bits' bits of value.
  function automatic int unsigned rev(input int unsigned value, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) r = (r << 1) | ((value >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly with a Q1.(TW-1) twiddle and a 1/2
// scale on both outputs so the full transform scales by 1/N.
module fft_butterfly
  import structs::*;
#(
  parameter int unsigned CALCULATION_SIZE = structs::CALCULATION_SIZE,
  parameter int unsigned TWIDDLE_SIZE     = structs::TWIDDLE_SIZE
) (
  input  logic signed [CALCULATION_SIZE-1:0] a_real,
  input  logic signed [CALCULATION_SIZE-1:0] a_imag,
  input  logic signed [CALCULATION_SIZE-1:0] b_real,
  input  logic signed [CALCULATION_SIZE-1:0] b_imag,
  input  logic signed [TWIDDLE_SIZE-1:0]     w_real,
  input  logic signed [TWIDDLE_SIZE-1:0]     w_imag,
  output logic signed [CALCULATION_SIZE-1:0] sum_real,
  output logic signed [CALCULATION_SIZE-1:0] sum_imag,
  output logic signed [CALCULATION_SIZE-1:0] diff_real,
  output logic signed [CALCULATION_SIZE-1:0] diff_imag
);

  localparam int unsigned CS = CALCULATION_SIZE;
  localparam int unsigned PW = CALCULATION_SIZE + TWIDDLE_SIZE;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]   t_real_full, t_imag_full;
  logic signed [CS+1:0] t_real, t_imag;
  logic signed [CS+1:0] s_real, s_imag, d_real, d_imag;

  always_comb begin
    p_rr = PW'(b_real) * PW'(w_real);
    p_ii = PW'(b_imag) * PW'(w_imag);
    p_ri = PW'(b_imag) * PW'(w_real);
    p_ir = PW'(b_real) * PW'(w_imag);

    t_real_full = (PW+1)'(p_rr) - (PW+1)'(p_ii);
    t_imag_full = (PW+1)'(p_ri) + (PW+1)'(p_ir);
    // Arithmetic shift truncates toward minus infinity.
    t_real = (CS+2)'(t_real_full >>> (TWIDDLE_SIZE - 1));
    t_imag = (CS+2)'(t_imag_full >>> (TWIDDLE_SIZE - 1));

    s_real = (CS+2)'(a_real) + t_real;
    s_imag = (CS+2)'(a_imag) + t_imag;
    d_real = (CS+2)'(a_real) - t_real;
    d_imag = (CS+2)'(a_imag) - t_imag;

    sum_real  = CS'(s_real >>> 1);
    sum_imag  = CS'(s_imag >>> 1);
    diff_real = CS'(d_real >>> 1);
    diff_imag = CS'(d_imag >>> 1);
  end

endmodule

// File: rtl/fft_n_point.sv
// N-point in-place radix-2 DIT FFT: load N real samples in bit-reversed order,
// run one butterfly per cycle, then stream bins 0..N-1 under valid/ready.
module fft_n_point
  import structs::*;
#(
  parameter int unsigned NUM_POINTS       = 8,
  parameter int unsigned SAMPLE_SIZE      = structs::SAMPLE_SIZE,
  parameter int unsigned TWIDDLE_SIZE     = structs::TWIDDLE_SIZE,
  parameter int unsigned CALCULATION_SIZE = structs::CALCULATION_SIZE
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic signed [SAMPLE_SIZE-1:0]            in_sample,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [TWIDDLE_SIZE*NUM_POINTS/2-1:0]     twiddles_real,
  input  logic [TWIDDLE_SIZE*NUM_POINTS/2-1:0]     twiddles_imag,
  output logic signed [CALCULATION_SIZE-1:0]       out_real,
  output logic signed [CALCULATION_SIZE-1:0]       out_imag,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam int unsigned AW   = log2(NUM_POINTS);
  localparam int unsigned SW   = 4;
  localparam int unsigned CS   = CALCULATION_SIZE;
  localparam int unsigned HALF = NUM_POINTS / 2;

  fft_state_e state_q;
  logic [AW-1:0] sample_cnt_q, bfly_cnt_q, bin_q;
  logic [SW-1:0] stage_q;

  logic signed [CS-1:0] ram_real [NUM_POINTS];
  logic signed [CS-1:0] ram_imag [NUM_POINTS];

  logic [AW-1:0] addr_a, addr_b, half_span, tw_idx, wr_addr;
  logic signed [TWIDDLE_SIZE-1:0] w_real, w_imag;
  logic signed [CS-1:0] sum_real, sum_imag, diff_real, diff_imag;
  logic accept, last_bfly, last_stage;

  assign accept     = in_valid && in_ready;
  assign last_bfly  = (bfly_cnt_q == AW'(HALF - 1));
  assign last_stage = (stage_q == SW'(AW - 1));

  // Group base is the butterfly index with the in-group offset bits split out.
  always_comb begin
    half_span = AW'(1) << stage_q;
    addr_a    = ((bfly_cnt_q >> stage_q) << (stage_q + SW'(1))) | (bfly_cnt_q & (half_span - AW'(1)));
    addr_b    = addr_a | half_span;
    tw_idx    = (bfly_cnt_q & (half_span - AW'(1))) << (SW'(AW - 1) - stage_q);
    w_real    = twiddles_real[tw_idx*TWIDDLE_SIZE +: TWIDDLE_SIZE];
    w_imag    = twiddles_imag[tw_idx*TWIDDLE_SIZE +: TWIDDLE_SIZE];
    wr_addr   = AW'(rev(32'(sample_cnt_q), AW));
  end

  fft_butterfly #(
    .CALCULATION_SIZE(CALCULATION_SIZE),
    .TWIDDLE_SIZE    (TWIDDLE_SIZE)
  ) u_butterfly (
    .a_real   (ram_real[addr_a]),
    .a_imag   (ram_imag[addr_a]),
    .b_real   (ram_real[addr_b]),
    .b_imag   (ram_imag[addr_b]),
    .w_real   (w_real),
    .w_imag   (w_imag),
    .sum_real (sum_real),
    .sum_imag (sum_imag),
    .diff_real(diff_real),
    .diff_imag(diff_imag)
  );

  // Working RAM carries no reset; every frame overwrites all N entries on load.
  always_ff @(posedge clock) begin
    if (accept) begin
      ram_real[wr_addr] <= CS'(in_sample);
      ram_imag[wr_addr] <= '0;
    end else if (state_q == StCompute) begin
      ram_real[addr_a] <= sum_real;
      ram_imag[addr_a] <= sum_imag;
      ram_real[addr_b] <= diff_real;
      ram_imag[addr_b] <= diff_imag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StLoad;
      sample_cnt_q <= '0;
      bfly_cnt_q   <= '0;
      stage_q      <= '0;
      bin_q        <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            if (sample_cnt_q == AW'(NUM_POINTS - 1)) begin
              sample_cnt_q <= '0;
              state_q      <= StCompute;
              in_ready     <= 1'b0;
              busy         <= 1'b1;
            end else begin
              sample_cnt_q <= sample_cnt_q + AW'(1);
            end
          end
        end
        StCompute: begin
          if (last_bfly) begin
            bfly_cnt_q <= '0;
            if (last_stage) begin
              stage_q   <= '0;
              bin_q     <= '0;
              state_q   <= StUnload;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end else begin
              stage_q <= stage_q + SW'(1);
            end
          end else begin
            bfly_cnt_q <= bfly_cnt_q + AW'(1);
          end
        end
        StUnload: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= StLoad;
              bin_q     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              bin_q    <= bin_q + AW'(1);
              out_last <= (bin_q == AW'(NUM_POINTS - 2));
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // RAM is frozen during unload, so the presented bin holds while stalled.
  assign out_real = out_valid ? ram_real[bin_q] : '0;
  assign out_imag = out_valid ? ram_imag[bin_q] : '0;

endmodule

// File: tb/tb_fft_n_point.sv
// Directed bench for fft_n_point at N=8: impulse, DC, Nyquist, shifted impulse,
// latency, backpressure and reset-abandon, against hand-computed bins.
module tb_fft_n_point;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [15:0] in_sample;
  logic               in_valid;
  logic               in_ready;
  logic        [63:0] twiddles_real;
  logic        [63:0] twiddles_imag;
  logic signed [19:0] out_real;
  logic signed [19:0] out_imag;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fft_n_point #(
    .NUM_POINTS      (8),
    .SAMPLE_SIZE     (16),
    .TWIDDLE_SIZE    (16),
    .CALCULATION_SIZE(20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .twiddles_real(twiddles_real),
    .twiddles_imag(twiddles_imag),
    .out_real     (out_real),
    .out_imag     (out_imag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic signed [19:0] obs, input int exp,
                         input int tol);
    vectors++;
    assert (!$isunknown(obs) && obs >= exp - tol && obs <= exp + tol) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents x[0..7]; returns at the first negedge after sample 7 was taken.
  task automatic send_frame(input string tag, input int x[8], input bit hold);
    int i;
    int budget;
    i = 0;
    budget = 200;
    while (i < 8 && budget > 0) begin
      @(negedge clock);
      in_valid  = 1'b1;
      in_sample = 16'(x[i]);
      if (in_ready) i++;
      budget--;
    end
    chk_int({tag, "_accepted"}, i, 8);
    @(negedge clock);
    in_valid  = hold;
    in_sample = 16'sd7777;
  endtask

  task automatic wait_bins(input string tag);
    int lat;
    chk_bit({tag, "_busy"}, busy, 1'b1);
    chk_bit({tag, "_in_ready_lo"}, in_ready, 1'b0);
    chk_bit({tag, "_valid_lo"}, out_valid, 1'b0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk_int({tag, "_latency"}, lat, 12);
  endtask

  task automatic collect(input string tag, input int er[8], input int ei[8], input bit rnd);
    int bin;
    int budget;
    bit stalled;
    logic signed [19:0] pr, pi;
    bin = 0;
    budget = 400;
    stalled = 1'b0;
    pr = '0;
    pi = '0;
    while (bin < 8 && budget > 0) begin
      if (out_valid === 1'b1) begin
        chk_val($sformatf("%s_re%0d", tag, bin), out_real, er[bin], 2);
        chk_val($sformatf("%s_im%0d", tag, bin), out_imag, ei[bin], 2);
        chk_bit($sformatf("%s_last%0d", tag, bin), out_last, logic'(bin == 7));
        if (stalled) begin
          chk_val($sformatf("%s_hold_re%0d", tag, bin), out_real, int'(pr), 0);
          chk_val($sformatf("%s_hold_im%0d", tag, bin), out_imag, int'(pi), 0);
        end
        pr = out_real;
        pi = out_imag;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !out_ready;
        if (out_ready) bin++;
      end
      @(negedge clock);
      budget--;
    end
    chk_int({tag, "_bins"}, bin, 8);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_bit({tag, "_end_valid"}, out_valid, 1'b0);
    chk_bit({tag, "_end_in_ready"}, in_ready, 1'b1);
    chk_bit({tag, "_end_busy"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int x[8], input int er[8], input int ei[8],
                           input bit rnd, input bit hold);
    send_frame(tag, x, hold);
    wait_bins(tag);
    collect(tag, er, ei, rnd);
  endtask

  int x_imp[8], x_dc[8], x_nyq[8], x_sh[8], x_junk[8];
  int e_imp_r[8], e_dc_r[8], e_nyq_r[8], e_sh_r[8], e_sh_i[8], e_zero[8];

  initial begin
    // Q1.15 twiddles, entry k in bits [16k +: 16]: cos(2pi k/8) and -sin(2pi k/8).
    twiddles_real = {16'hA57E, 16'h0000, 16'h5A82, 16'h7FFF};
    twiddles_imag = {16'hA57E, 16'h8001, 16'hA57E, 16'h0000};

    x_imp   = '{1000, 0, 0, 0, 0, 0, 0, 0};
    x_dc    = '{800, 800, 800, 800, 800, 800, 800, 800};
    x_nyq   = '{800, -800, 800, -800, 800, -800, 800, -800};
    x_sh    = '{0, 1000, 0, 0, 0, 0, 0, 0};
    x_junk  = '{5000, -5000, 3000, 2000, -1000, 700, 9, -32768};
    e_zero  = '{0, 0, 0, 0, 0, 0, 0, 0};
    e_imp_r = '{125, 125, 125, 125, 125, 125, 125, 125};
    // Unity twiddle is 32767, so each stage drops about one LSB on DC.
    e_dc_r  = '{797, 0, 0, 0, 0, 0, 0, 0};
    e_nyq_r = '{-1, 0, 0, 0, 799, 0, 0, 0};
    e_sh_r  = '{124, 88, 0, -89, -125, -88, 0, 88};
    e_sh_i  = '{0, -89, -125, -89, 0, 88, 125, 88};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_out_last", out_last, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_val("rst_out_real", out_real, 0, 0);
    chk_val("rst_out_imag", out_imag, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    chk_bit("post_rst_in_ready", in_ready, 1'b1);

    run_frame("impulse", x_imp, e_imp_r, e_zero, 1'b0, 1'b0);
    run_frame("dc", x_dc, e_dc_r, e_zero, 1'b0, 1'b0);
    run_frame("nyquist", x_nyq, e_nyq_r, e_zero, 1'b0, 1'b0);
    run_frame("shifted", x_sh, e_sh_r, e_sh_i, 1'b1, 1'b0);
    run_frame("stall_imp", x_imp, e_imp_r, e_zero, 1'b1, 1'b0);

    // Abandon a frame mid-compute with in_valid still asserted.
    send_frame("junk", x_junk, 1'b1);
    repeat (5) @(negedge clock);
    chk_bit("junk_busy", busy, 1'b1);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_bit("abort_in_ready", in_ready, 1'b1);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_out_valid", out_valid, 1'b0);

    run_frame("held_valid", x_imp, e_imp_r, e_zero, 1'b0, 1'b1);
    run_frame("after_held", x_sh, e_sh_r, e_sh_i, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
